// File: rtl/soc_reset_sequencer.sv
// Board-level reset sequencer: synchronizes/debounces the button and PLL lock, then releases
// peripheral and CPU resets in two timed stages. Optional watchdog restart under RST_SEQ_WDT_EN.
module soc_reset_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 256,
    parameter int unsigned STAGE_CYCLES    = 16,
    parameter int unsigned WDT_CYCLES      = 32'd1 << 20
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic       btn_in_i,
    input  logic       pll_lock_i,
    input  logic       wdt_kick_i,
    output logic       periph_reset_o,
    output logic       cpu_reset_o,
    output logic       busy_o,
    output logic [1:0] last_cause_o,
    output logic [7:0] reset_count_o
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned STG_W = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGE_CYCLES - 1);

    localparam logic [1:0] CAUSE_BTN = 2'd1;
    localparam logic [1:0] CAUSE_PLL = 2'd2;
    localparam logic [1:0] CAUSE_WDT = 2'd3;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_PERIPH,
        ST_CPU_WAIT,
        ST_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        btn_sync_q, lock_sync_q;
    logic              btn_s, lock_s;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              btn_db_q, btn_db_d, btn_db_prev_q;
    logic              btn_rise;
    logic [STG_W-1:0]  stg_cnt_q, stg_cnt_d;
    logic [1:0]        cause_q, cause_d;
    logic [7:0]        count_q, count_d;
    logic              periph_reset_q, periph_reset_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic              wdt_expire;
    logic              trig;
    logic [1:0]        trig_cause;

    assign btn_s    = btn_sync_q[1];
    assign lock_s   = lock_sync_q[1];
    assign btn_rise = btn_db_q & ~btn_db_prev_q;

    // Debounce: count how long btn_s has disagreed with the accepted level.
    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (btn_s != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = btn_s;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

`ifdef RST_SEQ_WDT_EN
    localparam int unsigned WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_q, wdt_d;

    // A kick on the expiry cycle suppresses the trigger.
    assign wdt_expire = (state_q == ST_RUN) && (wdt_q == WDT_LAST) && !wdt_kick_i;

    always_comb begin
        wdt_d = wdt_q + WDT_W'(1);
        if ((state_q != ST_RUN) || (state_d != ST_RUN) || wdt_kick_i) begin
            wdt_d = '0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    logic [32:0] unused_wdt;

    assign wdt_expire = 1'b0;
    assign unused_wdt = {wdt_kick_i, 32'(WDT_CYCLES)};
`endif

    assign trig       = !lock_s || wdt_expire || btn_rise;
    assign trig_cause = !lock_s ? CAUSE_PLL : (wdt_expire ? CAUSE_WDT : CAUSE_BTN);

    always_comb begin
        state_d   = state_q;
        stg_cnt_d = '0;
        cause_d   = cause_q;
        count_d   = count_q;
        case (state_q)
            ST_HOLD: begin
                if (lock_s && !btn_db_q) state_d = ST_PERIPH;
            end
            ST_PERIPH: begin
                if (stg_cnt_q == STG_LAST) state_d = ST_CPU_WAIT;
                else stg_cnt_d = stg_cnt_q + STG_W'(1);
            end
            ST_CPU_WAIT: begin
                if (stg_cnt_q == STG_LAST) state_d = ST_RUN;
                else stg_cnt_d = stg_cnt_q + STG_W'(1);
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: state_d = ST_HOLD;
        endcase
        // Restart triggers override the normal progression outside HOLD.
        if ((state_q != ST_HOLD) && trig) begin
            state_d = ST_HOLD;
            cause_d = trig_cause;
            if ((state_q == ST_RUN) && (count_q != 8'hFF)) begin
                count_d = count_q + 8'd1;
            end
        end
        if (state_d != state_q) stg_cnt_d = '0;

        periph_reset_d = (state_d == ST_HOLD) || (state_d == ST_PERIPH);
        cpu_reset_d    = (state_d != ST_RUN);
        busy_d         = (state_d != ST_RUN);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            btn_sync_q     <= '0;
            lock_sync_q    <= '0;
            db_cnt_q       <= '0;
            btn_db_q       <= 1'b0;
            btn_db_prev_q  <= 1'b0;
            state_q        <= ST_HOLD;
            stg_cnt_q      <= '0;
            cause_q        <= 2'd0;
            count_q        <= 8'd0;
            periph_reset_q <= 1'b1;
            cpu_reset_q    <= 1'b1;
            busy_q         <= 1'b1;
        end else begin
            btn_sync_q     <= {btn_sync_q[0], btn_in_i};
            lock_sync_q    <= {lock_sync_q[0], pll_lock_i};
            db_cnt_q       <= db_cnt_d;
            btn_db_q       <= btn_db_d;
            btn_db_prev_q  <= btn_db_q;
            state_q        <= state_d;
            stg_cnt_q      <= stg_cnt_d;
            cause_q        <= cause_d;
            count_q        <= count_d;
            periph_reset_q <= periph_reset_d;
            cpu_reset_q    <= cpu_reset_d;
            busy_q         <= busy_d;
        end
    end

    assign periph_reset_o = periph_reset_q;
    assign cpu_reset_o    = cpu_reset_q;
    assign busy_o         = busy_q;
    assign last_cause_o   = cause_q;
    assign reset_count_o  = count_q;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Self-checking bench for soc_reset_sequencer: directed vectors, corner sequences and
// randomized traffic compared against a timeline model of the release sequence.
module tb_soc_reset_sequencer;

    localparam int unsigned DEB = 8;
    localparam int unsigned STG = 4;
    localparam int unsigned WDT = 64;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn   = 1'b0;
    logic       lock  = 1'b0;
    logic       kick  = 1'b0;
    logic       periph_reset_o, cpu_reset_o, busy_o;
    logic [1:0] last_cause_o;
    logic [7:0] reset_count_o;

    int n_checks = 0;
    int n_err    = 0;

    soc_reset_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .STAGE_CYCLES   (STG),
        .WDT_CYCLES     (WDT)
    ) dut (
        .clock_i       (clk),
        .reset_n_i     (rst_n),
        .btn_in_i      (btn),
        .pll_lock_i    (lock),
        .wdt_kick_i    (kick),
        .periph_reset_o(periph_reset_o),
        .cpu_reset_o   (cpu_reset_o),
        .busy_o        (busy_o),
        .last_cause_o  (last_cause_o),
        .reset_count_o (reset_count_o)
    );

    always #5 clk = ~clk;

    // Reference model: sequence position is "cycles since HOLD was left".
    bit m_lk1, m_lk2, m_bt1, m_bt2, m_db, m_dbp, m_hold;
    int m_run, m_t, m_wdt, m_cause, m_count;

    function automatic void model_reset();
        {m_lk1, m_lk2, m_bt1, m_bt2, m_db, m_dbp} = '0;
        m_hold = 1'b1;
        m_run = 0; m_t = 0; m_wdt = 0; m_cause = 0; m_count = 0;
    endfunction

    function automatic void model_step(input bit b, input bit l, input bit k);
        bit lock_s, btn_s, was_run, now_run, rise, wexp;
        lock_s  = m_lk2;
        btn_s   = m_bt2;
        was_run = !m_hold && (m_t >= 2 * STG);
        rise    = m_db && !m_dbp;
        wexp    = 1'b0;
`ifdef RST_SEQ_WDT_EN
        wexp = was_run && (m_wdt == WDT - 1) && !k;
`endif
        if (m_hold) begin
            if (lock_s && !m_db) begin
                m_hold = 1'b0;
                m_t    = 0;
            end
        end else if (!lock_s || wexp || rise) begin
            m_cause = !lock_s ? 2 : (wexp ? 3 : 1);
            if (was_run && m_count < 255) m_count++;
            m_hold = 1'b1;
        end else if (m_t < 1000) begin
            m_t++;
        end
        now_run = !m_hold && (m_t >= 2 * STG);
        m_wdt   = (was_run && now_run && !k) ? m_wdt + 1 : 0;
        m_dbp   = m_db;
        if (btn_s != m_db) begin
            m_run++;
            if (m_run == DEB) begin
                m_db  = btn_s;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_lk2 = m_lk1; m_lk1 = l;
        m_bt2 = m_bt1; m_bt1 = b;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_periph", int'(periph_reset_o), int'(m_hold || (m_t < STG)));
        chk("m_cpu",    int'(cpu_reset_o),    int'(m_hold || (m_t < 2 * STG)));
        chk("m_busy",   int'(busy_o),         int'(m_hold || (m_t < 2 * STG)));
        chk("m_cause",  int'(last_cause_o),   m_cause);
        chk("m_count",  int'(reset_count_o),  m_count);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(btn, lock, kick);
        else model_reset();
        #1;
        check_model();
        kick = 1'b0;
    endtask

    task automatic wait_run(input string nm);
        for (int i = 0; i < 120; i++) begin
            if (!cpu_reset_o) break;
            tick();
        end
        chk(nm, int'(cpu_reset_o), 0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_periph"}, int'(periph_reset_o), 1);
        chk({nm, "_cpu"},    int'(cpu_reset_o),    1);
        chk({nm, "_busy"},   int'(busy_o),         1);
        chk({nm, "_cause"},  int'(last_cause_o),   0);
        chk({nm, "_count"},  int'(reset_count_o),  0);
    endtask

    typedef struct {
        bit b;
        bit l;
        bit exp_p;
        bit exp_c;
    } vec_t;

    vec_t pwr [14];

    initial begin
        int btn_left, lock_left, restart_edge;
        bit restarted;

        // Edges after reset release: PERIPH at 3, periph falls at 7, cpu at 11.
        pwr = '{'{0, 1, 1, 1}, '{0, 1, 1, 1}, '{0, 1, 1, 1}, '{0, 1, 1, 1},
                '{0, 1, 1, 1}, '{0, 1, 1, 1}, '{0, 1, 0, 1}, '{0, 1, 0, 1},
                '{0, 1, 0, 1}, '{0, 1, 0, 1}, '{0, 1, 0, 0}, '{0, 1, 0, 0},
                '{0, 1, 0, 0}, '{0, 1, 0, 0}};

        model_reset();
        lock = 1'b1;
        repeat (5) tick();
        chk_reset_vals("por");
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            btn  = pwr[i].b;
            lock = pwr[i].l;
            tick();
            chk("pwr_periph", int'(periph_reset_o), int'(pwr[i].exp_p));
            chk("pwr_cpu",    int'(cpu_reset_o),    int'(pwr[i].exp_c));
            chk("pwr_busy",   int'(busy_o),         int'(pwr[i].exp_c));
        end
        chk("pwr_cause", int'(last_cause_o), 0);
        chk("pwr_count", int'(reset_count_o), 0);

        // Glitch of 5 cycles is rejected.
        btn = 1'b1;
        repeat (5) tick();
        btn = 1'b0;
        repeat (15) tick();
        chk("glitch_cpu", int'(cpu_reset_o), 0);
        chk("glitch_count", int'(reset_count_o), 0);

        // Valid press: resets assert 11 edges after raw rise.
        btn = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 10) chk("press_cpu_e10", int'(cpu_reset_o), 0);
            if (e == 11) begin
                chk("press_periph_e11", int'(periph_reset_o), 1);
                chk("press_cpu_e11", int'(cpu_reset_o), 1);
                chk("press_cause", int'(last_cause_o), 1);
                chk("press_count", int'(reset_count_o), 1);
            end
        end
        btn = 1'b0;
        for (int r = 1; r <= 19; r++) begin
            tick();
            if (r == 14) chk("rel_periph_r14", int'(periph_reset_o), 1);
            if (r == 15) chk("rel_periph_r15", int'(periph_reset_o), 0);
            if (r == 18) chk("rel_cpu_r18", int'(cpu_reset_o), 1);
            if (r == 19) chk("rel_cpu_r19", int'(cpu_reset_o), 0);
        end

        // PLL loss and debounced button edge on the same cycle.
        btn = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 8) lock = 1'b0;
            if (e == 10) chk("sim_cpu_e10", int'(cpu_reset_o), 0);
            if (e == 11) begin
                chk("sim_periph_e11", int'(periph_reset_o), 1);
                chk("sim_cause", int'(last_cause_o), 2);
                chk("sim_count", int'(reset_count_o), 2);
            end
        end
        btn  = 1'b0;
        lock = 1'b1;
        wait_run("sim_release");

        // Watchdog with no kicks.
        restarted    = 1'b0;
        restart_edge = 0;
        for (int e = 1; e <= 100; e++) begin
            tick();
            if (cpu_reset_o) begin
                restarted    = 1'b1;
                restart_edge = e;
                break;
            end
        end
`ifdef RST_SEQ_WDT_EN
        chk("wdt_expire_edge", restart_edge, int'(WDT));
        chk("wdt_cause", int'(last_cause_o), 3);
        chk("wdt_count", int'(reset_count_o), 3);
        wait_run("wdt_release");
`else
        chk("nowdt_restart", int'(restarted), 0);
        chk("nowdt_cause", int'(last_cause_o), 2);
`endif

        // Regular kicks keep RUN alive.
        restarted = 1'b0;
        for (int e = 1; e <= 200; e++) begin
            if (e % 50 == 0) kick = 1'b1;
            tick();
            if (cpu_reset_o) restarted = 1'b1;
        end
        chk("kick_no_restart", int'(restarted), 0);

        // Randomized traffic against the model.
        btn_left  = 0;
        lock_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (btn_left > 0) btn_left--;
            else if ($urandom_range(0, 59) == 0) btn_left = int'($urandom_range(1, 20));
            if (lock_left > 0) lock_left--;
            else if ($urandom_range(0, 149) == 0) lock_left = int'($urandom_range(1, 6));
            btn  = (btn_left > 0);
            lock = (lock_left == 0);
            kick = ($urandom_range(0, 49) == 0);
            tick();
        end
        btn  = 1'b0;
        lock = 1'b1;
        kick = 1'b0;
        wait_run("rand_settle");

        // Saturating restart counter.
        for (int n = 0; n < 256; n++) begin
            wait_run("sat_run");
            lock = 1'b0;
            repeat (3) tick();
            lock = 1'b1;
        end
        wait_run("sat_final_run");
        chk("sat_count", int'(reset_count_o), 255);
        chk("sat_cause", int'(last_cause_o), 2);

        // Asynchronous reset during CPU_WAIT.
        lock = 1'b0;
        repeat (3) tick();
        lock = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!periph_reset_o && cpu_reset_o) break;
            tick();
        end
        chk("cpu_wait_reached", int'({periph_reset_o, cpu_reset_o}), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 6) chk("rerun_periph_e6", int'(periph_reset_o), 1);
            if (e == 7) chk("rerun_periph_e7", int'(periph_reset_o), 0);
            if (e == 10) chk("rerun_cpu_e10", int'(cpu_reset_o), 1);
            if (e == 11) chk("rerun_cpu_e11", int'(cpu_reset_o), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
